// File: rtl/ex_wb_stage.sv
// Execute stage plus EX/WB register: single-cycle ALU ops and an iterative
// shift-add multiplier that holds off the ID stage through ready_out.
module ex_wb_stage #(
  parameter int DATA_W  = 8,
  parameter int REG_AW  = 3,
  parameter bit R0_ZERO = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid_in,
  output logic              ready_out,
  input  logic [2:0]        opcode_in,
  input  logic [DATA_W-1:0] rs1_data_in,
  input  logic [DATA_W-1:0] rs2_data_in,
  input  logic [REG_AW-1:0] rd_in,
  output logic              wb_en,
  output logic [REG_AW-1:0] wb_rd,
  output logic [DATA_W-1:0] wb_data,
  output logic              busy
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_MUL  = 1'b1;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SHL = 3'b101;
  localparam logic [2:0] OP_MUL = 3'b110;
  localparam logic [2:0] OP_NOP = 3'b111;

  logic [0:0]        state_q, state_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [REG_AW-1:0] rd_q, rd_d;
  logic              wb_en_q, wb_en_d;
  logic [REG_AW-1:0] wb_rd_q, wb_rd_d;
  logic [DATA_W-1:0] wb_data_q, wb_data_d;

  logic [DATA_W-1:0] alu_res;
  logic [DATA_W-1:0] mul_sum;
  logic              rd_ok_in;
  logic              rd_ok_mul;

  assign ready_out = (state_q == S_IDLE);
  assign busy      = (state_q == S_MUL);
  assign wb_en     = wb_en_q;
  assign wb_rd     = wb_rd_q;
  assign wb_data   = wb_data_q;

  // A write to r0 still executes but never strobes the register file.
  assign rd_ok_in  = !(R0_ZERO && (rd_in == '0));
  assign rd_ok_mul = !(R0_ZERO && (rd_q == '0));

  assign mul_sum = acc_q + (b_q[0] ? a_q : '0);

  always_comb begin
    alu_res = '0;
    case (opcode_in)
      OP_ADD:  alu_res = rs1_data_in + rs2_data_in;
      OP_SUB:  alu_res = rs1_data_in - rs2_data_in;
      OP_AND:  alu_res = rs1_data_in & rs2_data_in;
      OP_OR:   alu_res = rs1_data_in | rs2_data_in;
      OP_XOR:  alu_res = rs1_data_in ^ rs2_data_in;
      OP_SHL:  alu_res = rs1_data_in << rs2_data_in[2:0];
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    rd_d      = rd_q;
    wb_en_d   = 1'b0;
    wb_rd_d   = wb_rd_q;
    wb_data_d = wb_data_q;

    case (state_q)
      S_IDLE: begin
        if (valid_in) begin
          if (opcode_in == OP_MUL) begin
            state_d = S_MUL;
            a_d     = rs1_data_in;
            b_d     = rs2_data_in;
            acc_d   = '0;
            cnt_d   = CNT_W'(DATA_W);
            rd_d    = rd_in;
          end else if ((opcode_in != OP_NOP) && rd_ok_in) begin
            wb_en_d   = 1'b1;
            wb_rd_d   = rd_in;
            wb_data_d = alu_res;
          end
        end
      end
      S_MUL: begin
        acc_d = mul_sum;
        a_d   = a_q << 1;
        b_d   = b_q >> 1;
        cnt_d = cnt_q - CNT_W'(1);
        // Final step: the updated sum is the truncated product.
        if (cnt_q == CNT_W'(1)) begin
          state_d = S_IDLE;
          if (rd_ok_mul) begin
            wb_en_d   = 1'b1;
            wb_rd_d   = rd_q;
            wb_data_d = mul_sum;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      a_q       <= '0;
      b_q       <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      rd_q      <= '0;
      wb_en_q   <= 1'b0;
      wb_rd_q   <= '0;
      wb_data_q <= '0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      rd_q      <= rd_d;
      wb_en_q   <= wb_en_d;
      wb_rd_q   <= wb_rd_d;
      wb_data_q <= wb_data_d;
    end
  end

endmodule

// File: tb/tb_ex_wb_stage.sv
// Self-checking bench for ex_wb_stage: vector table, multiply/stall/reset
// sequences and random traffic against an arithmetic reference model.
module tb_ex_wb_stage;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       valid_in;
  logic       ready_out;
  logic [2:0] opcode_in;
  logic [7:0] rs1_data_in;
  logic [7:0] rs2_data_in;
  logic [2:0] rd_in;
  logic       wb_en;
  logic [2:0] wb_rd;
  logic [7:0] wb_data;
  logic       busy;

  int pass_cnt  = 0;
  int total_cnt = 0;
  logic [2:0] last_rd   = '0;
  logic [7:0] last_data = '0;

  ex_wb_stage #(.DATA_W(8), .REG_AW(3), .R0_ZERO(1'b1)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .valid_in    (valid_in),
    .ready_out   (ready_out),
    .opcode_in   (opcode_in),
    .rs1_data_in (rs1_data_in),
    .rs2_data_in (rs2_data_in),
    .rd_in       (rd_in),
    .wb_en       (wb_en),
    .wb_rd       (wb_rd),
    .wb_data     (wb_data),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] rd;
    logic       exp_en;
    logic [7:0] exp_data;
  } vec_t;

  vec_t vecs [10];

  // Reference: plain integer arithmetic, reduced modulo 256.
  function automatic int ref_result(input int op, input int a, input int b);
    case (op)
      0: return (a + b) % 256;
      1: return (a - b + 256) % 256;
      2: return a & b;
      3: return a | b;
      4: return a ^ b;
      5: return (a * (2 ** (b % 8))) % 256;
      6: return (a * b) % 256;
      default: return 0;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic check_wb(input string tag, input logic en, input logic [2:0] rd,
                          input logic [7:0] data);
    chk({tag, "_en"}, {31'd0, wb_en}, {31'd0, en});
    if (en) begin
      chk({tag, "_rd"}, {29'd0, wb_rd}, {29'd0, rd});
      chk({tag, "_data"}, {24'd0, wb_data}, {24'd0, data});
      last_rd   = rd;
      last_data = data;
    end else begin
      chk({tag, "_hold_rd"}, {29'd0, wb_rd}, {29'd0, last_rd});
      chk({tag, "_hold_data"}, {24'd0, wb_data}, {24'd0, last_data});
    end
  endtask

  task automatic drive(input logic v, input logic [2:0] op, input logic [7:0] a,
                       input logic [7:0] b, input logic [2:0] rd);
    valid_in    = v;
    opcode_in   = op;
    rs1_data_in = a;
    rs2_data_in = b;
    rd_in       = rd;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 3'd7, 8'h00, 8'h00, 3'd0);
    #2;
    chk("rst_wb_en", {31'd0, wb_en}, 32'd0);
    chk("rst_wb_rd", {29'd0, wb_rd}, 32'd0);
    chk("rst_wb_data", {24'd0, wb_data}, 32'd0);
    chk("rst_ready", {31'd0, ready_out}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    vecs[0] = '{3'd0, 8'h7F, 8'h02, 3'd3, 1'b1, 8'h81};
    vecs[1] = '{3'd1, 8'h00, 8'h01, 3'd1, 1'b1, 8'hFF};
    vecs[2] = '{3'd5, 8'h81, 8'h03, 3'd2, 1'b1, 8'h08};
    vecs[3] = '{3'd0, 8'hFF, 8'h01, 3'd4, 1'b1, 8'h00};
    vecs[4] = '{3'd2, 8'hF0, 8'h3C, 3'd6, 1'b1, 8'h30};
    vecs[5] = '{3'd3, 8'hF0, 8'h0F, 3'd7, 1'b1, 8'hFF};
    vecs[6] = '{3'd4, 8'hAA, 8'hFF, 3'd1, 1'b1, 8'h55};
    vecs[7] = '{3'd0, 8'h11, 8'h22, 3'd0, 1'b0, 8'h00};
    vecs[8] = '{3'd7, 8'h11, 8'h22, 3'd5, 1'b0, 8'h00};
    vecs[9] = '{3'd5, 8'h01, 8'h0F, 3'd2, 1'b1, 8'h80};

    // First ADD alone, then a bubble: the strobe lasts exactly one cycle.
    drive(1'b1, vecs[0].op, vecs[0].a, vecs[0].b, vecs[0].rd);
    step();
    check_wb("add_single", 1'b1, 3'd3, 8'h81);
    drive(1'b0, 3'd7, 8'h00, 8'h00, 3'd0);
    step();
    check_wb("add_single_after", 1'b0, 3'd0, 8'h00);

    for (int i = 0; i < 10; i++) begin
      drive(1'b1, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].rd);
      step();
      check_wb($sformatf("vec%0d", i), vecs[i].exp_en, vecs[i].rd, vecs[i].exp_data);
    end
    drive(1'b0, 3'd7, 8'h00, 8'h00, 3'd0);
    step();
    check_wb("vec_idle", 1'b0, 3'd0, 8'h00);

    // MUL 0x0D*0x0B: eight stalled cycles, then one write-back.
    drive(1'b1, 3'd6, 8'h0D, 8'h0B, 3'd5);
    chk("mul_ready_pre", {31'd0, ready_out}, 32'd1);
    step();
    drive(1'b0, 3'd7, 8'h00, 8'h00, 3'd0);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("mul_stall%0d_ready", i), {31'd0, ready_out}, 32'd0);
      chk($sformatf("mul_stall%0d_busy", i), {31'd0, busy}, 32'd1);
      chk($sformatf("mul_stall%0d_en", i), {31'd0, wb_en}, 32'd0);
      step();
    end
    check_wb("mul_0d_0b", 1'b1, 3'd5, 8'h8F);
    chk("mul_done_ready", {31'd0, ready_out}, 32'd1);
    chk("mul_done_busy", {31'd0, busy}, 32'd0);
    step();
    check_wb("mul_after", 1'b0, 3'd0, 8'h00);

    // MUL 0xFF*0xFF with an ADD held on the inputs throughout the stall.
    drive(1'b1, 3'd6, 8'hFF, 8'hFF, 3'd6);
    step();
    drive(1'b1, 3'd0, 8'h10, 8'h20, 3'd2);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("held_stall%0d_ready", i), {31'd0, ready_out}, 32'd0);
      chk($sformatf("held_stall%0d_en", i), {31'd0, wb_en}, 32'd0);
      step();
    end
    check_wb("mul_ff_ff", 1'b1, 3'd6, 8'h01);
    chk("held_ready_e8", {31'd0, ready_out}, 32'd1);
    step();
    drive(1'b0, 3'd7, 8'h00, 8'h00, 3'd0);
    check_wb("held_add", 1'b1, 3'd2, 8'h30);
    step();
    check_wb("held_add_once", 1'b0, 3'd0, 8'h00);

    // Random back-to-back ALU/NOP ops, rd may be zero.
    for (int i = 0; i < 20; i++) begin
      int op, a, b, rd;
      op = $urandom_range(0, 6);
      if (op == 6) op = 7;
      a  = $urandom_range(0, 255);
      b  = $urandom_range(0, 255);
      rd = $urandom_range(0, 7);
      drive(1'b1, 3'(op), 8'(a), 8'(b), 3'(rd));
      step();
      check_wb($sformatf("rnd%0d_op%0d", i, op), (op != 7) && (rd != 0), 3'(rd),
               8'(ref_result(op, a, b)));
    end

    // Random multiplies.
    for (int i = 0; i < 4; i++) begin
      int a, b, rd;
      a  = $urandom_range(0, 255);
      b  = $urandom_range(0, 255);
      rd = $urandom_range(0, 7);
      drive(1'b1, 3'd6, 8'(a), 8'(b), 3'(rd));
      step();
      drive(1'b0, 3'd7, 8'h00, 8'h00, 3'd0);
      repeat (7) step();
      chk($sformatf("rmul%0d_pre_en", i), {31'd0, wb_en}, 32'd0);
      step();
      check_wb($sformatf("rmul%0d", i), rd != 0, 3'(rd), 8'(ref_result(6, a, b)));
    end
    drive(1'b0, 3'd7, 8'h00, 8'h00, 3'd0);
    step();

    // Reset during the fourth multiply cycle.
    drive(1'b1, 3'd0, 8'h01, 8'h01, 3'd1);
    step();
    check_wb("pre_rst_add", 1'b1, 3'd1, 8'h02);
    drive(1'b1, 3'd6, 8'h33, 8'h07, 3'd3);
    step();
    drive(1'b0, 3'd7, 8'h00, 8'h00, 3'd0);
    repeat (3) step();
    #1 rst_n = 1'b0;
    #1;
    chk("abort_wb_en", {31'd0, wb_en}, 32'd0);
    chk("abort_wb_rd", {29'd0, wb_rd}, 32'd0);
    chk("abort_wb_data", {24'd0, wb_data}, 32'd0);
    chk("abort_ready", {31'd0, ready_out}, 32'd1);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    last_rd   = '0;
    last_data = '0;
    for (int i = 0; i < 10; i++) begin
      step();
      chk($sformatf("abort_nopulse%0d", i), {31'd0, wb_en}, 32'd0);
    end
    chk("abort_ready_rel", {31'd0, ready_out}, 32'd1);
    drive(1'b1, 3'd0, 8'h05, 8'h06, 3'd7);
    step();
    drive(1'b0, 3'd7, 8'h00, 8'h00, 3'd0);
    check_wb("post_rst_add", 1'b1, 3'd7, 8'h0B);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
